cordic_exp_arb: RTL

Round-robin arbiter and result router that shares one `cordic_exp_plus` pipeline among `NREQ` independent requesters. It accepts at most one operand per cycle, drives the core's `iData`/`pre_vaild` inputs, and tracks the requester index of every in-flight operand in a tag shift register. Each `exp` result is returned to the requester that issued the operand. It sits between the per-channel control logic and the single exp core instance.

---
 rtl/cordic_exp_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cordic_exp_arb.sv
// Round-robin arbiter and result router sharing one cordic_exp_plus core among NREQ requesters.
// Optional tag/valid consistency check enabled by defining CORDIC_EXP_ARB_CHK_EN.
module cordic_exp_arb #(
  parameter int NREQ     = 4,
  parameter int WII      = 8,
  parameter int WOI      = 32,
  parameter int WOF      = 32,
  parameter int PIPELINE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_vaild,
  input  logic [NREQ*(WII+16)-1:0]      req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic signed [WII+15:0]        core_iData,
  output logic                          core_pre_vaild,
  input  logic signed [WOI+WOF-1:0]     core_exp,
  input  logic                          core_post_vaild,
  output logic [NREQ-1:0]               rsp_vaild,
  output logic signed [WOI+WOF-1:0]     rsp_data,
  output logic                          busy,
  output logic                          err
);

  localparam int LAT = PIPELINE + 2;
  localparam int IW  = WII + 16;
  localparam int OW  = WOI + WOF;
  localparam int TW  = $clog2(NREQ);
  localparam logic [TW:0] NREQ_W = (TW+1)'(NREQ);

  logic signed [IW-1:0] ops [NREQ];
  logic [TW-1:0]        rr_q, rr_d, issue_tag_q, issue_tag_d, grant_idx;
  logic [TW:0]          scan;
  logic                 grant_vld;
  logic signed [IW-1:0] core_idata_q, core_idata_d;
  logic                 core_pre_vaild_q, core_pre_vaild_d;
  logic [LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [TW-1:0]        tag_idx_q [LAT];
  logic [TW-1:0]        tag_idx_d [LAT];
  logic [NREQ-1:0]      rsp_vaild_q, rsp_vaild_d;
  logic signed [OW-1:0] rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;
  logic                 route;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign ops[g] = req_data[g*IW +: IW];
  end

  // Round-robin scan starting at rr; first active requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_q} + (TW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!grant_vld && req_vaild[scan[TW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[TW-1:0];
      end
    end
  end

  always_comb begin
    req_ready        = grant_vld ? (NREQ'(1) << grant_idx) : '0;
    rr_d             = rr_q;
    core_idata_d     = core_idata_q;
    issue_tag_d      = issue_tag_q;
    core_pre_vaild_d = grant_vld;
    if (grant_vld) begin
      rr_d         = (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + TW'(1);
      core_idata_d = ops[grant_idx];
      issue_tag_d  = grant_idx;
    end
  end

  // Tag pipe mirrors the core latency so each result finds its requester.
  always_comb begin
    tag_vld_d    = {tag_vld_q[LAT-2:0], core_pre_vaild_q};
    tag_idx_d[0] = issue_tag_q;
    for (int k = 1; k < LAT; k++) tag_idx_d[k] = tag_idx_q[k-1];
  end

`ifdef CORDIC_EXP_ARB_CHK_EN
  always_comb begin
    route = core_post_vaild & tag_vld_q[LAT-1];
    err_d = err_q | (core_post_vaild ^ tag_vld_q[LAT-1]);
  end
`else
  always_comb begin
    route = core_post_vaild;
    err_d = 1'b0;
  end
`endif

  always_comb begin
    rsp_vaild_d = route ? (NREQ'(1) << tag_idx_q[LAT-1]) : '0;
    rsp_data_d  = route ? core_exp : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q             <= '0;
      issue_tag_q      <= '0;
      core_idata_q     <= '0;
      core_pre_vaild_q <= 1'b0;
      tag_vld_q        <= '0;
      for (int k = 0; k < LAT; k++) tag_idx_q[k] <= '0;
      rsp_vaild_q      <= '0;
      rsp_data_q       <= '0;
      err_q            <= 1'b0;
    end else begin
      rr_q             <= rr_d;
      issue_tag_q      <= issue_tag_d;
      core_idata_q     <= core_idata_d;
      core_pre_vaild_q <= core_pre_vaild_d;
      tag_vld_q        <= tag_vld_d;
      for (int k = 0; k < LAT; k++) tag_idx_q[k] <= tag_idx_d[k];
      rsp_vaild_q      <= rsp_vaild_d;
      rsp_data_q       <= rsp_data_d;
      err_q            <= err_d;
    end
  end

  assign core_iData     = core_idata_q;
  assign core_pre_vaild = core_pre_vaild_q;
  assign rsp_vaild      = rsp_vaild_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = core_pre_vaild_q | (|tag_vld_q);
  assign err            = err_q;

endmodule
